bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter that feeds the 4-digit seven-segment scanner with the 16-bit packed-hex `data` word it multiplexes onto `LED[11:0]`. It accepts one unsigned binary value per valid/ready handshake and converts it with an iterative shift-add-3 (double-dabble) algorithm, one bit per clock. It presents four packed BCD digits (thousands in `[15:12]`, units in `[3:0]`). The output is held stable between conversions so the scanner can sample it continuously at its own divided rate.

---
 rtl/bin_to_bcd_seq_if.sv | 22 ++
 rtl/bin_to_bcd_seq.sv | 111 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake bundle between a binary producer and the BCD converter.
// The master side drives bin_in/bin_valid; the slave returns ready and the held result.
interface bin_to_bcd_seq_if #(
  parameter int IN_WIDTH = 14
);
  logic [IN_WIDTH-1:0] bin_in;
  logic                bin_valid;
  logic                bin_ready;
  logic [15:0]         bcd_out;
  logic                bcd_valid;
  logic                overflow;

  modport master (
    output bin_in, bin_valid,
    input  bin_ready, bcd_out, bcd_valid, overflow
  );

  modport slave (
    input  bin_in, bin_valid,
    output bin_ready, bcd_out, bcd_valid, overflow
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock; result held between runs.
// Latency IN_WIDTH+1 cycles from accept to bcd_valid; bin_ready is low while converting, no queueing.
module bin_to_bcd_seq #(
  parameter int IN_WIDTH = 14
) (
  input  logic             CLOCK_IN,
  input  logic             reset,
  bin_to_bcd_seq_if.slave  bus
);
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IN_WIDTH-1:0]   bin_q, bin_d;
  logic [15:0]           scratch_q, scratch_d;
  logic [CNT_W-1:0]      step_q, step_d;
  logic                  ovf_pend_q, ovf_pend_d;
  logic [15:0]           bcd_q, bcd_d;
  logic                  bcd_vld_q, bcd_vld_d;
  logic                  ovf_q, ovf_d;

  logic [15:0]           adj;
  logic [15+IN_WIDTH:0]  shifted;
  logic [31:0]           bin_ext;

  // Every digit is corrected from the same pre-step value; 4-bit adds drop any carry.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < 4; i++) begin
      if (scratch_q[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
      end
    end
    shifted = {adj, bin_q} << 1;
  end

  assign bin_ext = 32'(bus.bin_in);

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    scratch_d  = scratch_q;
    step_d     = step_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    bcd_vld_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.bin_valid) begin
          bin_d      = bus.bin_in;
          scratch_d  = '0;
          step_d     = '0;
          ovf_pend_d = (bin_ext > 32'd9999);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = shifted[15+IN_WIDTH:IN_WIDTH];
        bin_d     = shifted[IN_WIDTH-1:0];
        step_d    = step_q + CNT_W'(1);
        if (step_q == CNT_W'(IN_WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Overflow is decided at accept time, so the scratch digits are not trusted here.
        bcd_d     = ovf_pend_q ? 16'h9999 : scratch_q;
        ovf_d     = ovf_pend_q;
        bcd_vld_d = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_IN) begin
    if (reset) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      scratch_q  <= '0;
      step_q     <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      bcd_vld_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      scratch_q  <= scratch_d;
      step_q     <= step_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      bcd_vld_q  <= bcd_vld_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.bin_ready = (state_q == IDLE);
  assign bus.bcd_out   = bcd_q;
  assign bus.bcd_valid = bcd_vld_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq at IN_WIDTH 14, 4 and 16 against a cycle-level behavioural model.
module tb_bin_to_bcd_seq;
  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [ND];
  logic        bv  [ND];
  logic [31:0] bi  [ND];
  logic        o_rdy [ND];
  logic        o_vld [ND];
  logic        o_ovf [ND];
  logic [15:0] o_out [ND];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  bin_to_bcd_seq_if #(.IN_WIDTH(14)) if0 ();
  bin_to_bcd_seq_if #(.IN_WIDTH(4))  if1 ();
  bin_to_bcd_seq_if #(.IN_WIDTH(16)) if2 ();

  assign if0.bin_in = bi[0][13:0];
  assign if0.bin_valid = bv[0];
  assign if1.bin_in = bi[1][3:0];
  assign if1.bin_valid = bv[1];
  assign if2.bin_in = bi[2][15:0];
  assign if2.bin_valid = bv[2];
  assign o_rdy[0] = if0.bin_ready;
  assign o_vld[0] = if0.bcd_valid;
  assign o_ovf[0] = if0.overflow;
  assign o_out[0] = if0.bcd_out;
  assign o_rdy[1] = if1.bin_ready;
  assign o_vld[1] = if1.bcd_valid;
  assign o_ovf[1] = if1.overflow;
  assign o_out[1] = if1.bcd_out;
  assign o_rdy[2] = if2.bin_ready;
  assign o_vld[2] = if2.bcd_valid;
  assign o_ovf[2] = if2.overflow;
  assign o_out[2] = if2.bcd_out;

  bin_to_bcd_seq #(.IN_WIDTH(14)) dut0 (.CLOCK_IN(clk), .reset(rst[0]), .bus(if0.slave));
  bin_to_bcd_seq #(.IN_WIDTH(4))  dut1 (.CLOCK_IN(clk), .reset(rst[1]), .bus(if1.slave));
  bin_to_bcd_seq #(.IN_WIDTH(16)) dut2 (.CLOCK_IN(clk), .reset(rst[2]), .bus(if2.slave));

  function automatic int wid(int d);
    case (d)
      0:       return 14;
      1:       return 4;
      default: return 16;
    endcase
  endfunction

  // Decimal digits by plain arithmetic, saturated at 9999.
  function automatic logic [15:0] ref_bcd(int v);
    if (v > 9999) return 16'h9999;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: busy countdown of IN_WIDTH+1 edges after accept, result lands on the last one.
  int          m_cnt [ND];
  int          m_val [ND];
  logic [15:0] m_out [ND];
  logic        m_ovf [ND];
  logic        m_vld [ND];
  logic        m_acc [ND];

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < ND; d++) begin
      m_acc[d] = 1'b0;
      m_vld[d] = 1'b0;
      if (rst[d]) begin
        m_cnt[d] = 0;
        m_out[d] = 16'h0000;
        m_ovf[d] = 1'b0;
      end else if (m_cnt[d] == 0) begin
        if (bv[d]) begin
          m_cnt[d] = wid(d) + 1;
          m_val[d] = int'(bi[d] & ((32'd1 << wid(d)) - 32'd1));
          m_acc[d] = 1'b1;
        end
      end else begin
        m_cnt[d] = m_cnt[d] - 1;
        if (m_cnt[d] == 0) begin
          m_out[d] = ref_bcd(m_val[d]);
          m_ovf[d] = (m_val[d] > 9999);
          m_vld[d] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int d = 0; d < ND; d++) begin
        chk($sformatf("d%0d bin_ready", d), 32'(o_rdy[d]), 32'(m_cnt[d] == 0));
        chk($sformatf("d%0d bcd_valid", d), 32'(o_vld[d]), 32'(m_vld[d]));
        chk($sformatf("d%0d bcd_out", d), 32'(o_out[d]), 32'(m_out[d]));
        chk($sformatf("d%0d overflow", d), 32'(o_ovf[d]), 32'(m_ovf[d]));
      end
    end
  end

  task automatic send(int d, int v, bit keep);
    bit ok = 1'b0;
    bi[d] = v;
    bv[d] = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (m_acc[d]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!keep) bv[d] = 1'b0;
    chk($sformatf("d%0d accept %0d", d, v), 32'(ok), 32'd1);
  endtask

  task automatic wait_result(int d, logic [15:0] eo, logic eov, int elat, string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      if (m_acc[d]) bv[d] = 1'b0;
    end while (!o_vld[d] && n < 200);
    chk({nm, " latency"}, 32'(n), 32'(elat));
    chk({nm, " out"}, 32'(o_out[d]), 32'(eo));
    chk({nm, " ovf"}, 32'(o_ovf[d]), 32'(eov));
  endtask

  int          bnd_v   [9] = '{0, 9, 10, 999, 1000, 9999, 10000, 16383, 42};
  logic [15:0] bnd_e   [9] = '{16'h0000, 16'h0009, 16'h0010, 16'h0999, 16'h1000,
                               16'h9999, 16'h9999, 16'h9999, 16'h0042};
  logic        bnd_o   [9] = '{0, 0, 0, 0, 0, 0, 1, 1, 0};

  initial begin
    for (int d = 0; d < ND; d++) begin
      rst[d] = 1'b1;
      bv[d]  = 1'b0;
      bi[d]  = 32'd0;
    end
    repeat (2) @(negedge clk);
    chk("reset bcd_out", 32'(o_out[0]), 32'h0);
    chk("reset bin_ready", 32'(o_rdy[0]), 32'd1);
    for (int d = 0; d < ND; d++) rst[d] = 1'b0;

    fork
      begin : main_w14
        int n;
        send(0, 1234, 1'b0);
        wait_result(0, 16'h1234, 1'b0, 15, "w14 1234");
        repeat (100) @(negedge clk);
        chk("w14 hold out", 32'(o_out[0]), 32'h1234);

        for (int i = 0; i < 9; i++) begin
          send(0, bnd_v[i], 1'b0);
          wait_result(0, bnd_e[i], bnd_o[i], 15, $sformatf("w14 bnd %0d", bnd_v[i]));
        end

        send(0, 5678, 1'b1);
        bi[0] = 321;
        wait_result(0, 16'h5678, 1'b0, 15, "w14 b2b 5678");
        wait_result(0, 16'h0321, 1'b0, 16, "w14 b2b 0321");

        send(0, 4321, 1'b0);
        repeat (6) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk("w14 midrst ready", 32'(o_rdy[0]), 32'd1);
        chk("w14 midrst out", 32'(o_out[0]), 32'h0);
        chk("w14 midrst ovf", 32'(o_ovf[0]), 32'd0);
        n = 0;
        repeat (30) begin
          @(negedge clk);
          if (o_vld[0]) n++;
        end
        chk("w14 midrst no valid", 32'(n), 32'd0);
        send(0, 77, 1'b0);
        wait_result(0, 16'h0077, 1'b0, 15, "w14 77");

        for (int i = 0; i < 150; i++) begin
          int v;
          v = int'($urandom_range(16383, 0));
          repeat ($urandom_range(3, 0)) @(negedge clk);
          send(0, v, 1'b0);
          wait_result(0, ref_bcd(v), v > 9999, 15, $sformatf("w14 rnd %0d", v));
        end
      end
      begin : sweep_w4
        for (int v = 0; v < 16; v++) begin
          send(1, v, 1'b0);
          wait_result(1, ref_bcd(v), 1'b0, 5, $sformatf("w4 %0d", v));
        end
      end
      begin : sweep_w16
        for (int i = 0; i < 2000; i++) begin
          int v;
          v = int'($urandom_range(65535, 0));
          send(2, v, 1'b0);
          wait_result(2, ref_bcd(v), v > 9999, 17, $sformatf("w16 %0d", v));
        end
      end
    join

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
